// File: rtl/sequencer_pkg.sv
// Shared types, one-hot state constants and ring-step helpers for the state sequencer.
// Optional build macro SEQUENCER_DEBOUNCE_EN (used by btn_conditioner) adds a debounce filter.
package sequencer_pkg;

  localparam int unsigned NUM_STATES = 7;

  typedef logic [NUM_STATES-1:0] state_oh_t;

  localparam state_oh_t S0_OH = 7'b0000001;
  localparam state_oh_t S1_OH = 7'b0000010;
  localparam state_oh_t S2_OH = 7'b0000100;
  localparam state_oh_t S3_OH = 7'b0001000;
  localparam state_oh_t S4_OH = 7'b0010000;
  localparam state_oh_t S5_OH = 7'b0100000;
  localparam state_oh_t S6_OH = 7'b1000000;

  // Forward step: idle enters the ring at S1, S6 wraps to S1, idle is never re-entered.
  function automatic state_oh_t next_oh(input state_oh_t cur);
    case (cur)
      S0_OH:   next_oh = S1_OH;
      S1_OH:   next_oh = S2_OH;
      S2_OH:   next_oh = S3_OH;
      S3_OH:   next_oh = S4_OH;
      S4_OH:   next_oh = S5_OH;
      S5_OH:   next_oh = S6_OH;
      S6_OH:   next_oh = S1_OH;
      default: next_oh = S0_OH;
    endcase
  endfunction

  // Backward step: S1 wraps to S6; idle stays idle.
  function automatic state_oh_t prev_oh(input state_oh_t cur);
    case (cur)
      S1_OH:   prev_oh = S6_OH;
      S2_OH:   prev_oh = S1_OH;
      S3_OH:   prev_oh = S2_OH;
      S4_OH:   prev_oh = S3_OH;
      S5_OH:   prev_oh = S4_OH;
      S6_OH:   prev_oh = S5_OH;
      default: prev_oh = S0_OH;
    endcase
  endfunction

endpackage

// File: rtl/state_sequencer_fsm_if.sv
// Control/status bundle between the board inputs, the sequencer and the hex decoder.
// master drives buttons and controls; slave (the sequencer) drives state_oh and step_pulse.
interface state_sequencer_fsm_if;
  import sequencer_pkg::*;

  logic      btn_next;
  logic      btn_back;
  logic      clr;
  logic      auto_en;
  logic      hold;
  state_oh_t state_oh;
  logic      step_pulse;

  modport master (
    output btn_next,
    output btn_back,
    output clr,
    output auto_en,
    output hold,
    input  state_oh,
    input  step_pulse
  );

  modport slave (
    input  btn_next,
    input  btn_back,
    input  clr,
    input  auto_en,
    input  hold,
    output state_oh,
    output step_pulse
  );

endinterface

// File: rtl/btn_conditioner.sv
// Raw button to single-cycle press: 2-flop synchronizer, rising-edge detect, and an
// optional stability filter enabled by SEQUENCER_DEBOUNCE_EN.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic r_sync1;
  logic r_sync2;
  logic r_last;
  logic w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef SEQUENCER_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DebW-1:0] r_deb_cnt;
  logic            r_filt;

  // Filtered level follows the synchronized level only after DEBOUNCE_CYCLES mismatching clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_cnt <= '0;
      r_filt    <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DebW'(DEBOUNCE_CYCLES - 1)) begin
      r_deb_cnt <= '0;
      r_filt    <= r_sync2;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b0;
    end else begin
      r_last <= w_level;
    end
  end

  assign o_press = w_level & ~r_last;

endmodule

// File: rtl/state_sequencer_fsm.sv
// One-hot 7-state sequencer feeding the state-to-hex decoder: button step/back, clear,
// dwell-timer auto-advance and illegal-encoding recovery. Optional macro: SEQUENCER_DEBOUNCE_EN.
module state_sequencer_fsm
  import sequencer_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES    = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input logic                  clk,
  input logic                  rst_n,
  state_sequencer_fsm_if.slave seq_if
);

  if (DWELL_CYCLES < 2) begin : g_bad_dwell
    $error("DWELL_CYCLES must be >= 2");
  end

  localparam int unsigned DwellW = $clog2(DWELL_CYCLES);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);

  state_oh_t         r_state;
  state_oh_t         w_state_nxt;
  logic [DwellW-1:0] r_dwell;
  logic [DwellW-1:0] w_dwell_nxt;
  logic              r_step;
  logic              w_change;
  logic              w_press_next;
  logic              w_press_back;
  logic              w_legal;
  logic              w_idle;
  logic              w_dwell_en;
  logic              w_expire;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_next (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (seq_if.btn_next),
    .o_press(w_press_next)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_back (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (seq_if.btn_back),
    .o_press(w_press_back)
  );

  // Exactly one bit set: non-zero and no second bit left after clearing the lowest.
  assign w_legal    = (r_state != '0) && ((r_state & (r_state - 1'b1)) == '0);
  assign w_idle     = (r_state == S0_OH);
  assign w_dwell_en = seq_if.auto_en && !seq_if.hold && !w_idle;
  assign w_expire   = w_dwell_en && (r_dwell == DwellLast);

  always_comb begin
    w_state_nxt = r_state;
    w_dwell_nxt = r_dwell;

    if (!w_legal) begin
      w_state_nxt = S0_OH;
    end else if (seq_if.clr) begin
      w_state_nxt = S0_OH;
    end else if (w_press_next) begin
      w_state_nxt = next_oh(r_state);
    end else if (w_press_back && !w_idle) begin
      w_state_nxt = prev_oh(r_state);
    end else if (w_expire) begin
      w_state_nxt = next_oh(r_state);
    end

    w_change = (w_state_nxt != r_state);

    if (w_change || seq_if.clr || !seq_if.auto_en) begin
      w_dwell_nxt = '0;
    end else if (w_dwell_en) begin
      w_dwell_nxt = r_dwell + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S0_OH;
      r_dwell <= '0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dwell <= w_dwell_nxt;
      r_step  <= w_change;
    end
  end

  assign seq_if.state_oh   = r_state;
  assign seq_if.step_pulse = r_step;

endmodule

// File: tb/tb_state_sequencer_fsm.sv
// Scoreboard bench for state_sequencer_fsm: expected states are queued at stimulus time and
// popped by a monitor on every step_pulse. Covers SEQUENCER_DEBOUNCE_EN when defined.
module tb_state_sequencer_fsm;
  import sequencer_pkg::*;

  localparam int unsigned Dwell = 8;
  localparam int unsigned Deb   = 4;
`ifdef SEQUENCER_DEBOUNCE_EN
  localparam int Lat       = 2 + Deb;
  localparam int PressHold = Deb + 1;
`else
  localparam int Lat       = 2;
  localparam int PressHold = 1;
`endif

  localparam logic [6:0] ExpS0 = 7'b0000001;
  localparam logic [6:0] ExpS1 = 7'b0000010;
  localparam logic [6:0] ExpS2 = 7'b0000100;
  localparam logic [6:0] ExpS3 = 7'b0001000;
  localparam logic [6:0] ExpS4 = 7'b0010000;
  localparam logic [6:0] ExpS5 = 7'b0100000;
  localparam logic [6:0] ExpS6 = 7'b1000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  state_sequencer_fsm_if u_if ();

  state_sequencer_fsm #(
    .DWELL_CYCLES   (Dwell),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq_if(u_if)
  );

  int         errors = 0;
  int         checks = 0;
  logic [6:0] exp_q[$];
  logic [6:0] ring_seq[6];
  logic [6:0] up_seq[4];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_exp(input logic nxt, input logic bck, input logic [6:0] exp_state);
    exp_q.push_back(exp_state);
    u_if.btn_next = nxt;
    u_if.btn_back = bck;
    tick(PressHold);
    u_if.btn_next = 1'b0;
    u_if.btn_back = 1'b0;
    tick(Lat + 3);
    check("press_result", u_if.state_oh, exp_state);
  endtask

  // Monitor: every step_pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && u_if.step_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: got step_pulse with state %b, required no step",
                 u_if.state_oh);
      end else begin
        check("scoreboard", u_if.state_oh, exp_q.pop_front());
      end
    end
  end

  initial begin
    ring_seq = '{ExpS2, ExpS3, ExpS4, ExpS5, ExpS6, ExpS1};
    up_seq   = '{ExpS1, ExpS2, ExpS3, ExpS4};
    u_if.btn_next = 1'b0;
    u_if.btn_back = 1'b0;
    u_if.clr      = 1'b0;
    u_if.auto_en  = 1'b0;
    u_if.hold     = 1'b0;

    tick(2);
    check("reset_state", u_if.state_oh, ExpS0);
    check("reset_step", {6'b0, u_if.step_pulse}, 7'd0);
    rst_n = 1'b1;
    tick(1);

    // Press latency: high before edge k, state changes exactly at edge k+Lat.
    exp_q.push_back(ExpS1);
    u_if.btn_next = 1'b1;
    for (int i = 0; i <= Lat; i++) begin
      tick(1);
      if (i == PressHold - 1) u_if.btn_next = 1'b0;
      if (i == Lat - 1) check("latency_before", u_if.state_oh, ExpS0);
      if (i == Lat) begin
        check("latency_at", u_if.state_oh, ExpS1);
        check("latency_step", {6'b0, u_if.step_pulse}, 7'd1);
      end
    end
    tick(1);
    check("step_one_cycle", {6'b0, u_if.step_pulse}, 7'd0);
    tick(Lat + 3);

    // Held button gives one advance.
    exp_q.push_back(ExpS2);
    u_if.btn_next = 1'b1;
    tick(20);
    u_if.btn_next = 1'b0;
    tick(Lat + 3);
    check("hold_one_advance", u_if.state_oh, ExpS2);

    press_exp(1'b0, 1'b1, ExpS1);
    for (int i = 0; i < 6; i++) press_exp(1'b1, 1'b0, ring_seq[i]);
    press_exp(1'b0, 1'b1, ExpS6);

    exp_q.push_back(ExpS0);
    u_if.clr = 1'b1;
    tick(1);
    u_if.clr = 1'b0;
    tick(1);
    check("clr_to_s0", u_if.state_oh, ExpS0);

    // Back in S0 is ignored.
    u_if.btn_back = 1'b1;
    for (int i = 0; i <= Lat; i++) begin
      tick(1);
      if (i == PressHold - 1) u_if.btn_back = 1'b0;
      if (i == Lat) begin
        check("back_s0_state", u_if.state_oh, ExpS0);
        check("back_s0_step", {6'b0, u_if.step_pulse}, 7'd0);
      end
    end
    tick(Lat + 3);

    // Dwell: S3 -> S4 after exactly Dwell cycles; hold at count 3 delays by 5.
    for (int i = 0; i < 3; i++) press_exp(1'b1, 1'b0, up_seq[i]);
    exp_q.push_back(ExpS4);
    u_if.auto_en = 1'b1;
    tick(Dwell - 1);
    check("dwell_before", u_if.state_oh, ExpS3);
    tick(1);
    check("dwell_at", u_if.state_oh, ExpS4);
    exp_q.push_back(ExpS5);
    tick(3);
    u_if.hold = 1'b1;
    tick(5);
    u_if.hold = 1'b0;
    tick(Dwell - 4);
    check("hold_before", u_if.state_oh, ExpS4);
    tick(1);
    check("hold_at", u_if.state_oh, ExpS5);
    u_if.auto_en = 1'b0;

    // Auto-advance never leaves S0.
    exp_q.push_back(ExpS0);
    u_if.clr = 1'b1;
    tick(1);
    u_if.clr = 1'b0;
    u_if.auto_en = 1'b1;
    tick(3 * Dwell);
    check("auto_s0_stays", u_if.state_oh, ExpS0);
    u_if.auto_en = 1'b0;

    // Simultaneous next and back in S2: next wins, back not queued.
    press_exp(1'b1, 1'b0, ExpS1);
    press_exp(1'b1, 1'b0, ExpS2);
    press_exp(1'b1, 1'b1, ExpS3);
    tick(4);
    check("back_not_queued", u_if.state_oh, ExpS3);
    press_exp(1'b1, 1'b0, ExpS4);
    press_exp(1'b1, 1'b0, ExpS5);

    // clr in the same cycle as an accepted next press.
    exp_q.push_back(ExpS0);
    u_if.btn_next = 1'b1;
    tick(PressHold);
    u_if.btn_next = 1'b0;
    tick(Lat - PressHold);
    u_if.clr = 1'b1;
    tick(1);
    u_if.clr = 1'b0;
    check("clr_beats_next", u_if.state_oh, ExpS0);
    tick(Lat + 3);
    check("clr_press_dropped", u_if.state_oh, ExpS0);

    // Illegal encoding recovers to S0 with a step pulse.
    exp_q.push_back(ExpS0);
    force dut.r_state = 7'b0011000;
    #1;
    release dut.r_state;
    tick(1);
    check("illegal_recover", u_if.state_oh, ExpS0);
    check("illegal_step", {6'b0, u_if.step_pulse}, 7'd1);
    tick(1);
    check("illegal_step_end", {6'b0, u_if.step_pulse}, 7'd0);

    // Asynchronous reset mid-dwell in S4.
    for (int i = 0; i < 4; i++) press_exp(1'b1, 1'b0, up_seq[i]);
    u_if.auto_en = 1'b1;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_state", u_if.state_oh, ExpS0);
    check("async_reset_step", {6'b0, u_if.step_pulse}, 7'd0);
    @(negedge clk);
    u_if.auto_en = 1'b0;
    rst_n = 1'b1;
    tick(2);
    check("after_reset", u_if.state_oh, ExpS0);

`ifdef SEQUENCER_DEBOUNCE_EN
    // Glitch shorter than the filter is rejected; a long press lands at 2+Deb.
    u_if.btn_next = 1'b1;
    tick(3);
    u_if.btn_next = 1'b0;
    tick(12);
    check("glitch_rejected", u_if.state_oh, ExpS0);
    exp_q.push_back(ExpS1);
    u_if.btn_next = 1'b1;
    for (int i = 0; i <= Lat; i++) begin
      tick(1);
      if (i == Lat - 1) check("deb_before", u_if.state_oh, ExpS0);
      if (i == Lat) check("deb_at", u_if.state_oh, ExpS1);
    end
    tick(3);
    u_if.btn_next = 1'b0;
    tick(Lat + 3);
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_steps: got %0d unconsumed expectations, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/state_sequencer_fsm.md
Name: state_sequencer_fsm

Overview:
- One-hot 7-state sequencer that generates the per-state select lines consumed directly by the state-to-hex display decoder.
- Sits between the board push-buttons/switches and that decoder.
- Advances on a conditioned button press, steps back on a second button, or auto-advances after a programmable dwell time.
- Guarantees exactly one state line is high at all times after reset.

Parameters:
- DWELL_CYCLES, 50_000_000, clocks spent in each non-idle state before auto-advance (1 s at 50 MHz); legal range >= 2
- DEBOUNCE_CYCLES, 500_000, clocks an input must stay stable before acceptance (used only with DEBOUNCE_EN)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_next  input  1  raw asynchronous button, active-high, request next state
- btn_back  input  1  raw asynchronous button, active-high, request previous state
- clr  input  1  synchronous clear to S0, active-high, already in clk domain
- auto_en  input  1  enables dwell-timer auto-advance
- hold  input  1  freezes dwell timer, count retained
- state_oh  output  7  one-hot state; bit n high = state Sn; bit n drives decoder input stateIn_n
- step_pulse  output  1  one-cycle pulse on every state change

Behaviour:
- Reset (rst_n low, async): state_oh = 7'b0000001 (S0); step_pulse = 0; dwell count = 0; all synchronizer/edge registers = 0.
- States: S0 = idle. S1..S6 = active ring.
- Input conditioning: btn_next and btn_back each pass through a 2-flop synchronizer plus a rising-edge detector. A button high at clock edge k yields its accepted press at edge k+2; state_oh updates on that edge. Holding a button produces only one press.
- Next-state priority, evaluated each cycle: clr > next press > back press > dwell expiry.
- clr: go to S0, count = 0; a press in the same cycle is discarded.
- next: S0->S1, Sn->Sn+1, S6->S1 (wrap; S0 is never re-entered by next).
- back: S1->S6, Sn->Sn-1 for n=2..6; back in S0 is ignored (no step_pulse).
- Simultaneous next and back: next wins; back is discarded, not queued.
- Dwell counter (width $clog2(DWELL_CYCLES)):
  - Increments when auto_en=1, hold=0 and state != S0.
  - When it equals DWELL_CYCLES-1 and is enabled, the next edge performs a next transition and clears it. Each active state therefore lasts exactly DWELL_CYCLES enabled cycles.
  - Clears on every state change from any source.
  - hold=1 freezes it; auto_en=0 clears it and keeps it at 0.
- Auto-advance never leaves S0.
- step_pulse is registered and high for the one cycle after state_oh changes.
- Illegal encoding (not exactly one bit set, e.g. an upset): the next edge forces S0 and asserts step_pulse; no other transition is taken that cycle.
- rst_n asserted mid-count or mid-press: immediate return to reset values. A press in flight is lost.

Optional Feature:
- Macro: SEQUENCER_DEBOUNCE_EN
- Defined: after synchronization, each button must hold a new level for DEBOUNCE_CYCLES consecutive clocks before its filtered level updates. The edge detector runs on the filtered level, so press latency = 2 + DEBOUNCE_CYCLES clocks. Bounces shorter than DEBOUNCE_CYCLES are rejected.
- Undefined: no filter; latency 2 clocks as above; DEBOUNCE_CYCLES unused.

Decomposition:
- Package sequencer_pkg:
  - NUM_STATES = 7
  - typedef state_oh_t (logic [6:0])
  - localparams S0_OH..S6_OH (one-hot constants)
  - function next_oh / prev_oh (ring rules above)
- Sub-module btn_conditioner: synchronizer, optional debounce, rising-edge pulse output. Instantiated twice (next, back).
- FSM, dwell counter and illegal-state check live in the top module.

Test Plan:
- Run with DWELL_CYCLES=8, DEBOUNCE_CYCLES=4.
- Reset, then pulse btn_next high 1 cycle at edge k -> state_oh=7'b0000010 at edge k+2, step_pulse high the following cycle; hold btn_next 20 cycles -> only one advance.
- From S1, six next presses -> sequence S2,S3,S4,S5,S6,S1 (wrap, no S0); then back from S1 -> S6; back in S0 -> no change, step_pulse stays 0.
- In S3 with auto_en=1 -> S4 after exactly 8 cycles; assert hold for 5 cycles at count 3 -> advance delayed by exactly 5 cycles; auto_en=1 in S0 -> remains S0 indefinitely.
- btn_next and btn_back accepted in the same cycle in S2 -> S3; clr with next in same cycle in S5 -> S0.
- Force state_oh to 7'b0011000 -> S0 (7'b0000001) next edge with step_pulse; assert rst_n low mid-dwell in S4 -> state_oh=7'b0000001 immediately, without waiting for a clock edge.
- With SEQUENCER_DEBOUNCE_EN, 3-cycle glitch on btn_next -> no transition; 10-cycle press -> transition at 2+4 cycles after rise.
